ufp_from_fp32_pipe: RTL and testbench

Synthesizable, pipelined converter from IEEE-754 single-precision bit patterns to an unsigned fixed-point (ufp) value in WL.QW format (IW = WL-QW). It replaces simulation-only real-to-ufp conversion in datapaths that must run in hardware, for example scene constants loaded from memory. Rounding, saturation and exception flags are defined in hardware. Both sides use a valid/ready handshake with full backpressure.

---
 rtl/ufp_from_fp32_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_ufp_from_fp32_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ufp_from_fp32_pipe.sv
// ---------------------------------------------------------------------------
// ufp_from_fp32_pipe
//
// Two-stage pipelined converter from an IEEE-754 single-precision bit pattern
// to an unsigned fixed-point value in WL.QW format (IW = WL - QW integer bits).
// Rounding, overflow handling and exception flags are fully defined in
// hardware, so this block can replace simulation-only real-to-ufp conversion
// (e.g. for scene constants loaded from memory).
//
//   S1: unpack, classify, align (integer part + guard bit, pre-round overflow)
//   S2: round, detect post-round overflow, saturate or wrap, drive outputs
//
// Parameters
//   WL            total output word length (2..32)
//   QW            output fraction bits (0 <= QW < WL)
//   SATURATE      1: overflow clamps to all-ones; 0: wrap to the low WL bits
//   ROUND_NEAREST 1: round to nearest, ties away from zero; 0: truncate
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_valid   in_bits is valid
//   in_ready   block accepts in_bits this cycle (no path from in_valid)
//   in_bits    fp32 bit pattern
//   out_valid  result is valid
//   out_ready  consumer accepts the result
//   out_val    ufp result
//   out_ovf    magnitude >= 2^IW after rounding, or input was +inf
//   out_neg    input was negative and nonzero; out_val forced to 0
//   out_nan    input was NaN; out_val forced to 0
// ---------------------------------------------------------------------------
module ufp_from_fp32_pipe #(
  parameter int WL            = 16,
  parameter int QW            = 8,
  parameter bit SATURATE      = 1'b1,
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_bits,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_val,
  output logic          out_ovf,
  output logic          out_neg,
  output logic          out_nan
);

  localparam int IW = WL - QW;

  // Input classes resolved in S1; S2 only does arithmetic for CLS_NORM.
  typedef enum logic [2:0] {
    CLS_NORM,  // positive normal number
    CLS_ZERO,  // zero or denormal of either sign (denormals flush to zero)
    CLS_NAN,   // any NaN
    CLS_PINF,  // +infinity
    CLS_NEG    // negative nonzero, including -infinity
  } cls_e;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic s1_valid;
  logic s1_adv;   // S1 contents move into S2 this cycle

  // Both terms are registered state or out_ready, so in_ready never depends
  // on in_valid.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  // -------------------------------------------------------------------------
  // S1 combinational: unpack, classify, align
  // -------------------------------------------------------------------------
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic [23:0] in_mant;

  assign in_sign = in_bits[31];
  assign in_exp  = in_bits[30:23];
  assign in_frac = in_bits[22:0];
  assign in_mant = {1'b1, in_frac};

  cls_e cls_d;

  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can infer a latch.
    cls_d = CLS_NORM;
    if (in_exp == 8'hFF) begin
      if (in_frac != '0) cls_d = CLS_NAN;
      else if (in_sign)  cls_d = CLS_NEG;
      else               cls_d = CLS_PINF;
    end else if (in_exp == 8'h00) begin
      cls_d = CLS_ZERO;
    end else if (in_sign) begin
      cls_d = CLS_NEG;
    end
  end

  // Scaled value is M * 2^sh with sh = e - 150 + QW. Only the low WL bits of
  // the integer part are kept: in range they hold the whole result, and on
  // overflow they are exactly what wrap mode must emit. Sticky is not kept
  // because ties-away rounding depends on the guard bit alone.
  int          sh;
  int          rsh_amt;
  logic [24:0] rsh;       // {integer part, guard} after a right shift
  logic [WL-1:0] int_d;
  logic        guard_d;
  logic        pre_ovf_d;

  always_comb begin
    sh        = int'(in_exp) - 150 + QW;
    rsh_amt   = -sh;
    rsh       = '0;
    int_d     = '0;
    guard_d   = 1'b0;
    pre_ovf_d = (int'(in_exp) - 127) >= IW;
    if (sh >= 0) begin
      // Exact left shift; shifts of WL or more leave no bits in the word.
      if (sh < WL) int_d = WL'({32'd0, in_mant} << sh[4:0]);
    end else if (rsh_amt < 26) begin
      rsh     = {in_mant, 1'b0} >> rsh_amt[4:0];
      int_d   = WL'(rsh[24:1]);
      guard_d = rsh[0];
    end
    // Right shifts of 26 or more: integer 0, guard 0 (defaults above).
  end

  // -------------------------------------------------------------------------
  // S1 registers
  // -------------------------------------------------------------------------
  cls_e          s1_cls;
  logic [WL-1:0] s1_int;
  logic          s1_guard;
  logic          s1_pre_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: payload registers carry no reset; they are only ever observed
  // while the matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_cls     <= cls_d;
      s1_int     <= int_d;
      s1_guard   <= guard_d;
      s1_pre_ovf <= pre_ovf_d;
    end
  end

  // -------------------------------------------------------------------------
  // S2 combinational: round, overflow, saturate/wrap
  // -------------------------------------------------------------------------
  logic          rnd;
  logic [WL:0]   sum;     // one extra bit catches the rounding carry
  logic [WL-1:0] val_d;
  logic          ovf_d;
  logic          neg_d;
  logic          nan_d;

  always_comb begin
    rnd   = ROUND_NEAREST ? s1_guard : 1'b0;
    sum   = {1'b0, s1_int} + {{WL{1'b0}}, rnd};
    val_d = '0;
    ovf_d = 1'b0;
    neg_d = 1'b0;
    nan_d = 1'b0;
    case (s1_cls)
      CLS_NAN:  nan_d = 1'b1;
      CLS_NEG:  neg_d = 1'b1;
      CLS_ZERO: val_d = '0;
      // +inf saturates whatever SATURATE says.
      CLS_PINF: begin
        val_d = '1;
        ovf_d = 1'b1;
      end
      default: begin
        ovf_d = s1_pre_ovf || sum[WL];
        val_d = (ovf_d && SATURATE) ? '1 : sum[WL-1:0];
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // S2 registers (the outputs). These are reset so the port values are
  // defined as zero during and right after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_val   <= '0;
      out_ovf   <= 1'b0;
      out_neg   <= 1'b0;
      out_nan   <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_val <= val_d;
        out_ovf <= ovf_d;
        out_neg <= neg_d;
        out_nan <= nan_d;
      end
    end
  end

endmodule

// File: tb/tb_ufp_from_fp32_pipe.sv
// ---------------------------------------------------------------------------
// tb_ufp_from_fp32_pipe
//
// Self-checking bench for ufp_from_fp32_pipe (WL=16, QW=8). Three instances
// share one input stream and one out_ready:
//   inst 0: SATURATE=1, ROUND_NEAREST=1 (defaults)
//   inst 1: SATURATE=0, ROUND_NEAREST=1 (wrap)
//   inst 2: SATURATE=1, ROUND_NEAREST=0 (truncate)
// Each directed vector carries hand-computed expectations for all three.
// Expected results are queued per instance on acceptance; a monitor pops and
// compares whenever an instance hands over a result.
// ---------------------------------------------------------------------------
module tb_ufp_from_fp32_pipe;

  localparam int WL = 16;
  localparam int QW = 8;
  localparam int N  = 3;

  // Flag encodings: {nan, neg, ovf}
  localparam logic [2:0] F0 = 3'b000;
  localparam logic [2:0] OV = 3'b001;
  localparam logic [2:0] NG = 3'b010;
  localparam logic [2:0] NN = 3'b100;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic [31:0]   in_bits   = '0;
  logic          out_ready = 1'b0;
  logic          in_ready  [N];
  logic          out_valid [N];
  logic [WL-1:0] out_val   [N];
  logic          out_ovf   [N];
  logic          out_neg   [N];
  logic          out_nan   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    ufp_from_fp32_pipe #(
      .WL(WL),
      .QW(QW),
      .SATURATE(g != 1),
      .ROUND_NEAREST(g != 2)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready[g]),
      .in_bits(in_bits),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .out_val(out_val[g]),
      .out_ovf(out_ovf[g]),
      .out_neg(out_neg[g]),
      .out_nan(out_nan[g])
    );
  end

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [18:0] sb [N][$];   // expected {nan, neg, ovf, val} per instance
  logic [18:0] cur_exp [N]; // expectations for the word currently on in_bits
  logic [18:0] mon_act;
  logic [18:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: sample away from the active edge. Pop before push so a result
  // can never be matched against the word accepted on the same edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      // The coming edge is a reset edge: everything in flight is discarded.
      for (int k = 0; k < N; k++) sb[k].delete();
    end else begin
      for (int k = 0; k < N; k++) begin
        if (out_valid[k] && out_ready) begin
          mon_act = {out_nan[k], out_neg[k], out_ovf[k], out_val[k]};
          check($sformatf("out%0d_expected", k), 32'(sb[k].size() != 0), 32'd1);
          if (sb[k].size() != 0) begin
            mon_exp = sb[k].pop_front();
            check($sformatf("out%0d", k), 32'(mon_act), 32'(mon_exp));
          end
        end
        if (in_valid && in_ready[k]) sb[k].push_back(cur_exp[k]);
      end
    end
  end

  // Present one word and hold it until accepted; returns the number of
  // cycles it waited. Leaves in_valid low #1 after the accepting edge.
  task automatic send(input logic [31:0] bits, input logic [18:0] e0,
                      input logic [18:0] e1, input logic [18:0] e2, output int waits);
    in_valid   = 1'b1;
    in_bits    = bits;
    cur_exp[0] = e0;
    cur_exp[1] = e1;
    cur_exp[2] = e2;
    waits      = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready[0]) break;
      waits++;
      if (waits > 50) begin
        check("send_timeout", 32'(in_ready[0]), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic vec(input logic [31:0] bits,
                     input logic [15:0] v0, input logic [2:0] f0,
                     input logic [15:0] v1, input logic [2:0] f1,
                     input logic [15:0] v2, input logic [2:0] f2);
    int w;
    send(bits, {f0, v0}, {f1, v1}, {f2, v2}, w);
  endtask

  task automatic drain;
    int n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
  endtask

  initial begin
    int w;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_word", 32'({out_nan[0], out_neg[0], out_ovf[0], out_val[0]}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready[0]), 32'd1);
    check("out_valid_after_rst", 32'(out_valid[0]), 32'd0);

    // ---------------- directed vectors, streamed back-to-back ----------------
    @(posedge clk);
    #1 out_ready = 1'b1;
    //        bits          inst0 (sat,rn)  inst1 (wrap,rn)  inst2 (sat,trunc)
    vec(32'h3FC00000, 16'h0180, F0, 16'h0180, F0, 16'h0180, F0); // 1.5
    vec(32'h437FFF00, 16'hFFFF, F0, 16'hFFFF, F0, 16'hFFFF, F0); // 255.99609375, max
    vec(32'h437FFF80, 16'hFFFF, OV, 16'h0000, OV, 16'hFFFF, F0); // tie rounds up to 256
    vec(32'h437FFFC0, 16'hFFFF, OV, 16'h0000, OV, 16'hFFFF, F0); // rounds to 256
    vec(32'h3B000000, 16'h0001, F0, 16'h0001, F0, 16'h0000, F0); // 2^-9, half LSB
    vec(32'h3A800000, 16'h0000, F0, 16'h0000, F0, 16'h0000, F0); // 2^-10, below half
    vec(32'h3F80C000, 16'h0102, F0, 16'h0102, F0, 16'h0101, F0); // 257.5 LSBs
    vec(32'h30800000, 16'h0000, F0, 16'h0000, F0, 16'h0000, F0); // 2^-30, shift >= 26
    vec(32'h00000001, 16'h0000, F0, 16'h0000, F0, 16'h0000, F0); // denormal
    vec(32'h80000001, 16'h0000, F0, 16'h0000, F0, 16'h0000, F0); // negative denormal
    vec(32'h7FC00000, 16'h0000, NN, 16'h0000, NN, 16'h0000, NN); // NaN
    vec(32'h7F800000, 16'hFFFF, OV, 16'hFFFF, OV, 16'hFFFF, OV); // +inf
    vec(32'hFF800000, 16'h0000, NG, 16'h0000, NG, 16'h0000, NG); // -inf
    vec(32'hBF800000, 16'h0000, NG, 16'h0000, NG, 16'h0000, NG); // -1.0
    vec(32'h80000000, 16'h0000, F0, 16'h0000, F0, 16'h0000, F0); // -0
    vec(32'h43800000, 16'hFFFF, OV, 16'h0000, OV, 16'hFFFF, OV); // 256, pre-round ovf
    vec(32'h43960000, 16'hFFFF, OV, 16'h2C00, OV, 16'hFFFF, OV); // 300, wraps
    vec(32'h477FFFFF, 16'hFFFF, OV, 16'hFFFF, OV, 16'hFFFF, OV); // sh = 0
    vec(32'h53800000, 16'hFFFF, OV, 16'h0000, OV, 16'hFFFF, OV); // 2^40, sh >= WL
    drain();

    // ---------------- backpressure ----------------
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h3F800000, {F0, 16'h0100}, {F0, 16'h0100}, {F0, 16'h0100}, w);
    check("bp_accept1_wait", 32'(w), 32'd0);
    send(32'h40000000, {F0, 16'h0200}, {F0, 16'h0200}, {F0, 16'h0200}, w);
    check("bp_accept2_wait", 32'(w), 32'd0);
    in_valid   = 1'b1;
    in_bits    = 32'h40400000;
    cur_exp[0] = {F0, 16'h0300};
    cur_exp[1] = {F0, 16'h0300};
    cur_exp[2] = {F0, 16'h0300};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
      check("bp_out_valid_hold", 32'(out_valid[0]), 32'd1);
      check("bp_out_val_hold", 32'(out_val[0]), 32'h0100);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    fork
      begin
        send(32'h40400000, {F0, 16'h0300}, {F0, 16'h0300}, {F0, 16'h0300}, w);
        send(32'h40800000, {F0, 16'h0400}, {F0, 16'h0400}, {F0, 16'h0400}, w);
      end
      begin
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check("bp_no_gap", 32'(out_valid[0]), 32'd1);
        end
      end
    join
    drain();

    // ---------------- reset with both stages full ----------------
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h3FC00000, {F0, 16'h0180}, {F0, 16'h0180}, {F0, 16'h0180}, w);
    send(32'h40000000, {F0, 16'h0200}, {F0, 16'h0200}, {F0, 16'h0200}, w);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++)
      check($sformatf("midrst_out_valid%0d", k), 32'(out_valid[k]), 32'd0);
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    check("midrst_out_word", 32'({out_nan[0], out_neg[0], out_ovf[0], out_val[0]}), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    vec(32'h40400000, 16'h0300, F0, 16'h0300, F0, 16'h0300, F0);
    drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
